// File: rtl/text_writer.sv
// text_writer: terminal-style byte stream to character RAM writer with cursor, row clear and screen clear.
module text_writer #(
  parameter int COLS     = 40,
  parameter int ROWS     = 30,
  parameter int COL_BITS = 6,
  parameter int ROW_BITS = 5
) (
  input  logic                         px_clk,
  input  logic                         rstn,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ROW_BITS+COL_BITS-1:0] waddr,
  output logic [7:0]                   wdata,
  output logic                         write_en,
  output logic [ROW_BITS-1:0]          cursor_row,
  output logic [COL_BITS-1:0]          cursor_col
);
  typedef enum logic [1:0] {CLEAR_SCREEN, IDLE, CLEAR_ROW, WRAP} state_t;
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS:0]   COLS_W   = (COL_BITS + 1)'(COLS);
  localparam logic [ROW_BITS:0]   ROWS_W   = (ROW_BITS + 1)'(ROWS);
  state_t                      state_q, state_d;
  logic [ROW_BITS-1:0]         row_q, row_d, next_row;
  logic [COL_BITS-1:0]         col_q, col_d;
  logic [ROW_BITS:0]           clr_r_q, clr_r_d;
  logic [COL_BITS:0]           clr_c_q, clr_c_d;
  logic                        we_q, we_d, rdy_q, rdy_d;
  logic [ROW_BITS+COL_BITS-1:0] waddr_q, waddr_d;
  logic [7:0]                  wdata_q, wdata_d;
  logic                        accept, printable;
  assign next_row  = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
  assign accept    = in_valid && rdy_q;
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    clr_r_d = clr_r_q;
    clr_c_d = clr_c_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rdy_d   = 1'b0;
    case (state_q)
      CLEAR_SCREEN: begin
        if (clr_r_q == ROWS_W) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end else begin
          we_d    = 1'b1;
          waddr_d = {clr_r_q[ROW_BITS-1:0], clr_c_q[COL_BITS-1:0]};
          wdata_d = 8'h20;
          clr_c_d = (clr_c_q == COLS_W - 1'b1) ? '0 : clr_c_q + 1'b1;
          clr_r_d = (clr_c_q == COLS_W - 1'b1) ? clr_r_q + 1'b1 : clr_r_q;
        end
      end
      CLEAR_ROW: begin
        if (clr_c_q == COLS_W) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end else begin
          we_d    = 1'b1;
          waddr_d = {row_q, clr_c_q[COL_BITS-1:0]};
          wdata_d = 8'h20;
          clr_c_d = clr_c_q + 1'b1;
        end
      end
      WRAP: begin
        // the cursor already sits on the new row; start clearing it
        we_d    = 1'b1;
        waddr_d = {row_q, {COL_BITS{1'b0}}};
        wdata_d = 8'h20;
        clr_c_d = (COL_BITS + 1)'(1);
        state_d = CLEAR_ROW;
      end
      default: begin
        rdy_d = 1'b1;
        if (accept) begin
          if (printable) begin
            we_d    = 1'b1;
            waddr_d = {row_q, col_q};
            wdata_d = in_data;
            col_d   = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
            row_d   = (col_q == LAST_COL) ? next_row : row_q;
            state_d = (col_q == LAST_COL) ? WRAP : IDLE;
            rdy_d   = (col_q != LAST_COL);
          end else if (in_data == 8'h0A) begin
            we_d    = 1'b1;
            waddr_d = {next_row, {COL_BITS{1'b0}}};
            wdata_d = 8'h20;
            col_d   = '0;
            row_d   = next_row;
            clr_c_d = (COL_BITS + 1)'(1);
            state_d = CLEAR_ROW;
            rdy_d   = 1'b0;
          end else if (in_data == 8'h0D) begin
            col_d = '0;
          end else if (in_data == 8'h08 && col_q != '0) begin
            we_d    = 1'b1;
            waddr_d = {row_q, col_q - 1'b1};
            wdata_d = 8'h20;
            col_d   = col_q - 1'b1;
          end else if (in_data == 8'h0C) begin
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = 8'h20;
            row_d   = '0;
            col_d   = '0;
            clr_r_d = '0;
            clr_c_d = (COL_BITS + 1)'(1);
            state_d = CLEAR_SCREEN;
            rdy_d   = 1'b0;
          end
        end
      end
    endcase
  end
  always_ff @(posedge px_clk) begin
    if (!rstn) begin
      state_q <= CLEAR_SCREEN;
      row_q   <= '0;
      col_q   <= '0;
      clr_r_q <= '0;
      clr_c_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      clr_r_q <= clr_r_d;
      clr_c_q <= clr_c_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
    end
  end
  assign in_ready   = rdy_q;
  assign write_en   = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed vector table plus hand-written multi-cycle sequences for text_writer.
module tb_text_writer;
  logic        px_clk = 1'b0;
  logic        rstn, in_valid, in_ready, write_en;
  logic [7:0]  in_data, wdata;
  logic [10:0] waddr;
  logic [4:0]  cursor_row;
  logic [5:0]  cursor_col;
  int pass_cnt = 0, total_cnt = 0;
  text_writer dut (
    .px_clk(px_clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .waddr(waddr), .wdata(wdata), .write_en(write_en),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );
  always #5 px_clk = ~px_clk;
  typedef struct {
    logic [7:0]  d;
    logic        we;
    logic [10:0] a;
    logic [7:0]  w;
    logic [4:0]  r;
    logic [5:0]  c;
  } vec_t;
  vec_t tbl[14];
  task automatic step();
    @(posedge px_clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask
  task automatic issue(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 3000) begin
      step();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic check_clear_row(input logic [4:0] row, input bit first_now);
    int errs = 0;
    for (int c = 0; c < 40; c++) begin
      if (!(first_now && c == 0)) step();
      if (!write_en || waddr !== {row, 6'(c)} || wdata !== 8'h20 || in_ready) errs++;
    end
    chk("row_clear_writes", 32'(errs), 32'd0);
    step();
    chk("row_clear_done", {30'd0, in_ready, write_en}, 32'b10);
  endtask
  task automatic check_screen(input bit first_now);
    int errs = 0;
    for (int i = 0; i < 1200; i++) begin
      if (!(first_now && i == 0)) step();
      if (!write_en || waddr !== {5'(i / 40), 6'(i % 40)} || wdata !== 8'h20 || in_ready) errs++;
    end
    chk("screen_clear_writes", 32'(errs), 32'd0);
    step();
    chk("screen_clear_done", {30'd0, in_ready, write_en}, 32'b10);
    chk("screen_clear_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
  endtask
  initial begin
    tbl[0]  = '{8'h41, 1'b1, 11'h000, 8'h41, 5'd0, 6'd1};
    tbl[1]  = '{8'h42, 1'b1, 11'h001, 8'h42, 5'd0, 6'd2};
    tbl[2]  = '{8'h0D, 1'b0, 11'h001, 8'h42, 5'd0, 6'd0};
    tbl[3]  = '{8'h08, 1'b0, 11'h001, 8'h42, 5'd0, 6'd0};
    tbl[4]  = '{8'h43, 1'b1, 11'h000, 8'h43, 5'd0, 6'd1};
    tbl[5]  = '{8'h44, 1'b1, 11'h001, 8'h44, 5'd0, 6'd2};
    tbl[6]  = '{8'h45, 1'b1, 11'h002, 8'h45, 5'd0, 6'd3};
    tbl[7]  = '{8'h08, 1'b1, 11'h002, 8'h20, 5'd0, 6'd2};
    tbl[8]  = '{8'h07, 1'b0, 11'h002, 8'h20, 5'd0, 6'd2};
    tbl[9]  = '{8'h9B, 1'b0, 11'h002, 8'h20, 5'd0, 6'd2};
    tbl[10] = '{8'h7F, 1'b0, 11'h002, 8'h20, 5'd0, 6'd2};
    tbl[11] = '{8'h20, 1'b1, 11'h002, 8'h20, 5'd0, 6'd3};
    tbl[12] = '{8'h7E, 1'b1, 11'h003, 8'h7E, 5'd0, 6'd4};
    tbl[13] = '{8'h0D, 1'b0, 11'h003, 8'h7E, 5'd0, 6'd0};
    rstn = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) step();
    chk("reset_outputs", {write_en, in_ready, waddr, wdata, cursor_row, cursor_col}, 32'd0);
    rstn = 1'b1;
    check_screen(1'b0);
    for (int i = 0; i < 14; i++) begin
      in_data  = tbl[i].d;
      in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d", i), {in_ready, write_en, waddr, wdata, cursor_row, cursor_col},
          {1'b1, tbl[i].we, tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].c});
    end
    in_valid = 1'b0;
    begin
      int errs = 0;
      for (int i = 0; i < 40; i++) begin
        in_data  = 8'h41 + 8'(i % 26);
        in_valid = 1'b1;
        step();
        if (!write_en || waddr !== {5'd0, 6'(i)} || wdata !== 8'h41 + 8'(i % 26)) errs++;
        if (in_ready !== (i < 39)) errs++;
      end
      in_valid = 1'b0;
      chk("line40_writes", 32'(errs), 32'd0);
      chk("line40_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd1, 6'd0});
    end
    check_clear_row(5'd1, 1'b0);
    for (int r = 2; r < 30; r++) begin
      issue(8'h0A);
      check_clear_row(5'(r), 1'b1);
    end
    for (int i = 0; i < 5; i++) issue(8'h61);
    chk("cursor_29_5", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd29, 6'd5});
    issue(8'h0A);
    chk("lf_wrap_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
    check_clear_row(5'd0, 1'b1);
    for (int r = 1; r < 4; r++) begin
      issue(8'h0A);
      check_clear_row(5'(r), 1'b1);
    end
    for (int i = 0; i < 7; i++) issue(8'h62);
    issue(8'h0D);
    chk("cr_3_7", {20'd0, in_ready, write_en, cursor_row, cursor_col}, {20'd0, 1'b1, 1'b0, 5'd3, 6'd0});
    issue(8'h0C);
    chk("ff_first", {20'd0, write_en, in_ready, cursor_row, cursor_col}, {20'd0, 1'b1, 1'b0, 11'd0});
    check_screen(1'b1);
    issue(8'h0A);
    check_clear_row(5'd1, 1'b1);
    issue(8'h0A);
    check_clear_row(5'd2, 1'b1);
    issue(8'h08);
    chk("bs_col0", {20'd0, in_ready, write_en, cursor_row, cursor_col}, {20'd0, 1'b1, 1'b0, 5'd2, 6'd0});
    for (int i = 0; i < 3; i++) issue(8'h63);
    issue(8'h08);
    chk("bs_col3", {in_ready, write_en, waddr, wdata, cursor_row, cursor_col},
        {1'b1, 1'b1, 11'h082, 8'h20, 5'd2, 6'd2});
    issue(8'h07);
    chk("drop_07", {20'd0, in_ready, write_en, cursor_row, cursor_col}, {20'd0, 1'b1, 1'b0, 5'd2, 6'd2});
    issue(8'h9B);
    chk("drop_9b", {20'd0, in_ready, write_en, cursor_row, cursor_col}, {20'd0, 1'b1, 1'b0, 5'd2, 6'd2});
    issue(8'h0C);
    repeat (499) step();
    chk("ff_500th_write", {20'd0, write_en, waddr}, {20'd0, 1'b1, 5'd12, 6'd19});
    rstn = 1'b0;
    step();
    chk("mid_clear_reset", {20'd0, write_en, in_ready, cursor_row, cursor_col}, 32'd0);
    step();
    chk("mid_clear_reset_hold", {20'd0, write_en, in_ready, cursor_row, cursor_col}, 32'd0);
    rstn = 1'b1;
    check_screen(1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
